// File: rtl/bit_serial_alu_sequencer.sv
// Bit-serial ALU: one operand bit per RUN cycle, LSB first, with a shared carry
// flop for ADD/SUB. bit_sel exposes the active bit index to external bit muxes.
module bit_serial_alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             err,
  output logic [3:0]       bit_sel
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;
  localparam logic [3:0] LAST_IDX = 4'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg;
  logic [2:0]       op_reg;
  logic [3:0]       idx_reg;
  logic             carry_reg, cout_reg, zero_reg, err_reg, done_reg, busy_reg;

  logic             a_bit, b_bit, b_eff, is_arith, r_bit, carry_next;
  logic [WIDTH-1:0] result_next;

  always_comb begin
    a_bit    = a_reg[idx_reg];
    b_bit    = b_reg[idx_reg];
    is_arith = (op_reg == OP_ADD) || (op_reg == OP_SUB);
    // Subtraction is a + ~b with the carry preset to 1 at capture.
    b_eff    = (op_reg == OP_SUB) ? ~b_bit : b_bit;
    carry_next = carry_reg;
    r_bit    = 1'b0;
    case (op_reg)
      OP_ADD, OP_SUB: begin
        r_bit      = a_bit ^ b_eff ^ carry_reg;
        carry_next = (a_bit & b_eff) | (a_bit & carry_reg) | (b_eff & carry_reg);
      end
      OP_AND:  r_bit = a_bit & b_bit;
      OP_OR:   r_bit = a_bit | b_bit;
      OP_XOR:  r_bit = a_bit ^ b_bit;
      OP_NOT:  r_bit = ~a_bit;
      OP_PASS: r_bit = a_bit;
      default: r_bit = 1'b0;
    endcase
    result_next          = result_reg;
    result_next[idx_reg] = r_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= OP_ADD;
      idx_reg    <= '0;
      carry_reg  <= 1'b0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      zero_reg   <= 1'b1;
      err_reg    <= 1'b0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            if (op == OP_ILL) begin
              err_reg   <= 1'b1;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              a_reg      <= a;
              b_reg      <= b;
              op_reg     <= op;
              idx_reg    <= '0;
              carry_reg  <= (op == OP_SUB);
              result_reg <= '0;
              err_reg    <= 1'b0;
              busy_reg   <= 1'b1;
              state_reg  <= RUN;
            end
          end
        end
        RUN: begin
          result_reg <= result_next;
          carry_reg  <= carry_next;
          if (idx_reg == LAST_IDX) begin
            cout_reg  <= is_arith ? carry_next : 1'b0;
            zero_reg  <= (result_next == '0);
            // idx returns to 0 so bit_sel reads 0 outside RUN.
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 4'd1;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          err_reg   <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign result  = result_reg;
  assign cout    = cout_reg;
  assign zero    = zero_reg;
  assign err     = err_reg;
  assign bit_sel = idx_reg;

endmodule
